// File: rtl/out_display.sv
// out_display: decimal display driver for the CPU's 8-bit output register.
// A sequential double-dabble engine converts value to three BCD digits. The
// conversion starts only when value differs from the last sampled value. The
// result is scanned onto a 4-digit multiplexed 7-segment display with leading
// zeros blanked.
// Optional feature (macro OUT_DISPLAY_SIGNED_EN): value is treated as two's
// complement; the magnitude is converted and digit 3 shows a minus sign.
//
// Handshake note: there is no valid/ready pair here. value is sampled on any
// IDLE clock where it differs from the shadow copy. busy is high from the
// clock after that sample until the clock on which bcd is updated.
module out_display #(
    parameter int REFRESH_DIV = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  dig_en
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [7:0]             shadow;
    logic [7:0]             bin;
    logic [11:0]            work;
    logic [2:0]             iter;
    logic                   start;
    logic [7:0]             magnitude;
    logic [11:0]            adjusted;
    logic [19:0]            shifted;
    logic [REFRESH_DIV-1:0] refresh_cnt;
    logic [1:0]             digit_idx;
    logic [6:0]             digit_seg;

`ifdef OUT_DISPLAY_SIGNED_EN
    logic                   sign;
`endif

    // Add 3 to a BCD nibble of 5 or more so the following shift carries correctly.
    function automatic logic [3:0] dabble(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Decimal digit to segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign start = (state == IDLE) && (value != shadow);
    assign busy  = (state != IDLE);

`ifdef OUT_DISPLAY_SIGNED_EN
    // -128 maps to 8'h80, which is 128 when read as unsigned.
    assign magnitude = value[7] ? (~value + 8'd1) : value;
`else
    assign magnitude = value;
`endif

    assign adjusted = {dabble(work[11:8]), dabble(work[7:4]), dabble(work[3:0])};
    assign shifted  = {adjusted, bin} << 1;

    // Converter state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic: one shift per clock for 8 clocks, then one commit clock.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (iter == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Conversion datapath: sample, shift-and-adjust, commit to bcd only in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= 8'd0;
            bin    <= 8'd0;
            work   <= 12'd0;
            iter   <= 3'd0;
            bcd    <= 12'd0;
`ifdef OUT_DISPLAY_SIGNED_EN
            sign   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        shadow <= value;
                        bin    <= magnitude;
                        work   <= 12'd0;
                        iter   <= 3'd0;
`ifdef OUT_DISPLAY_SIGNED_EN
                        sign   <= value[7];
`endif
                    end
                end
                SHIFT: begin
                    work <= shifted[19:8];
                    bin  <= shifted[7:0];
                    iter <= iter + 3'd1;
                end
                DONE:    bcd <= work;
                default: ;
            endcase
        end
    end

    // Refresh counter; the scanned digit advances when the counter is all ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            if (&refresh_cnt) digit_idx <= digit_idx + 2'd1;
        end
    end

    // Pattern for the currently scanned digit, with leading-zero blanking.
    always_comb begin
        digit_seg = 7'h00;
        case (digit_idx)
            2'd0: digit_seg = seg7(bcd[3:0]);
            2'd1: if (bcd[11:8] != 4'd0 || bcd[7:4] != 4'd0) digit_seg = seg7(bcd[7:4]);
            2'd2: if (bcd[11:8] != 4'd0) digit_seg = seg7(bcd[11:8]);
`ifdef OUT_DISPLAY_SIGNED_EN
            2'd3: if (sign) digit_seg = 7'h40;
`else
            2'd3: digit_seg = 7'h00;
`endif
            default: digit_seg = 7'h00;
        endcase
    end

    // Registered display outputs; dig_en is active-low one-hot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seg    <= 7'h00;
            dig_en <= 4'b1111;
        end else begin
            seg    <= digit_seg;
            dig_en <= ~(4'b0001 << digit_idx);
        end
    end

endmodule

// File: tb/tb_out_display.sv
// Bench for out_display with a fast refresh (REFRESH_DIV=2).
// The reference model works from decimal arithmetic: every sample queues the
// expected decimal result, and the result is retired 9 clocks later.
module tb_out_display;

    localparam int RD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  value = 8'd0;
    logic [11:0] bcd;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  dig_en;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    out_display #(.REFRESH_DIV(RD)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .value  (value),
        .bcd    (bcd),
        .busy   (busy),
        .seg    (seg),
        .dig_en (dig_en)
    );

    // Clock and reset are driven here and from the main sequence below.
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected decimal digits of a sampled value.
    function automatic logic [11:0] to_bcd(input logic [7:0] v);
        int m;
        m = int'(v);
`ifdef OUT_DISPLAY_SIGNED_EN
        if (v[7]) m = 256 - int'(v);
`endif
        return 12'((m / 100) * 256 + ((m / 10) % 10) * 16 + (m % 10));
    endfunction

    // Expected segment pattern for a digit position, from the blanking rules.
    function automatic logic [6:0] exp_seg(input int idx, input logic [11:0] b, input logic sgn);
        logic [3:0] h, t, o;
        h = b[11:8];
        t = b[7:4];
        o = b[3:0];
        case (idx)
            0:       return seg_tab[o];
            1:       return (h != 0 || t != 0) ? seg_tab[t] : 7'h00;
            2:       return (h != 0) ? seg_tab[h] : 7'h00;
            default: return sgn ? 7'h40 : 7'h00;
        endcase
    endfunction

    // Reference model state.
    logic [7:0]  m_shadow;
    int          m_left;
    logic [11:0] m_bcd;
    logic        m_sign;
    int          m_cnt;
    int          m_idx;
    logic [6:0]  m_seg;
    logic [3:0]  m_dig;
    logic [11:0] exp_q[$];

    // Reference model: sample when idle and changed, retire the result 9 clocks later.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_q.delete();
            m_shadow <= 8'd0;
            m_left   <= 0;
            m_bcd    <= 12'd0;
            m_sign   <= 1'b0;
            m_cnt    <= 0;
            m_idx    <= 0;
            m_seg    <= 7'h00;
            m_dig    <= 4'b1111;
        end else begin
            if (m_left == 0) begin
                if (value != m_shadow) begin
                    m_shadow <= value;
                    m_left   <= 9;
                    exp_q.push_back(to_bcd(value));
`ifdef OUT_DISPLAY_SIGNED_EN
                    m_sign   <= value[7];
`endif
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1 && exp_q.size() > 0) m_bcd <= exp_q.pop_front();
            end
            m_seg <= exp_seg(m_idx, m_bcd, m_sign);
            m_dig <= ~(4'b0001 << m_idx);
            m_cnt <= (m_cnt + 1) % (1 << RD);
            if (m_cnt == (1 << RD) - 1) m_idx <= (m_idx + 1) % 4;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && reset_n) begin
            check("busy", 32'(busy), 32'(m_left != 0));
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("seg", 32'(seg), 32'(m_seg));
            check("dig_en", 32'(dig_en), 32'(m_dig));
        end
    end

    // Wait for the conversion triggered by the last input change to finish.
    task automatic run_to_idle();
        @(negedge clk);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Record one full scan and compare the pattern shown on each digit.
    task automatic scan_check(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] got [4];
        for (int i = 0; i < 4; i++) got[i] = 7'h7F;
        repeat (4 * (1 << RD)) begin
            @(negedge clk);
            case (dig_en)
                4'b1110: got[0] = seg;
                4'b1101: got[1] = seg;
                4'b1011: got[2] = seg;
                4'b0111: got[3] = seg;
                default: ;
            endcase
        end
        check({tag, "_d0"}, 32'(got[0]), 32'(e0));
        check({tag, "_d1"}, 32'(got[1]), 32'(e1));
        check({tag, "_d2"}, 32'(got[2]), 32'(e2));
        check({tag, "_d3"}, 32'(got[3]), 32'(e3));
    endtask

    initial begin
        int busy_len;
        int gap;

        // Reset with value=0.
        reset_n = 1'b0;
        value   = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dig_en", 32'(dig_en), 32'hF);
        check("rst_seg", 32'(seg), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (3) @(negedge clk);
        check("no_start", 32'(busy), 32'd0);
        scan_check("zero", 7'h3F, 7'h00, 7'h00, 7'h00);

        // 255: busy length and full scan.
        value    = 8'd255;
        busy_len = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
            busy_len++;
        end
        check("busy_len", 32'(busy_len), 32'd9);
        check("bcd_255", 32'(bcd), 32'h255);
        @(negedge clk);
        scan_check("s255", 7'h6D, 7'h6D, 7'h5B, 7'h00);

        // 7: tens and hundreds blanked.
        value = 8'd7;
        run_to_idle();
        check("bcd_7", 32'(bcd), 32'h007);
        @(negedge clk);
        scan_check("s7", 7'h07, 7'h00, 7'h00, 7'h00);

        // 100 then 42 while still converting.
        value = 8'd100;
        repeat (3) @(negedge clk);
        value = 8'd42;
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("bcd_100", 32'(bcd), 32'h100);
        gap = 0;
        while (!busy && gap < 5) begin
            gap++;
            @(negedge clk);
        end
        check("idle_gap", 32'(gap), 32'd1);
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("bcd_42", 32'(bcd), 32'h042);

        // Asynchronous reset in the middle of a conversion.
        value = 8'd200;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_bcd", 32'(bcd), 32'h000);
        @(negedge clk);
        reset_n = 1'b1;
        run_to_idle();
        check("bcd_200", 32'(bcd), 32'h200);

        // Top-bit-set input: unsigned or signed interpretation.
        value = 8'hF6;
        run_to_idle();
        @(negedge clk);
`ifdef OUT_DISPLAY_SIGNED_EN
        check("bcd_m10", 32'(bcd), 32'h010);
        scan_check("sm10", 7'h3F, 7'h06, 7'h00, 7'h40);
        value = 8'h80;
        run_to_idle();
        check("bcd_m128", 32'(bcd), 32'h128);
`else
        check("bcd_246", 32'(bcd), 32'h246);
        scan_check("s246", 7'h7D, 7'h66, 7'h5B, 7'h00);
`endif

        // Random values held for random spans, some shorter than a conversion.
        for (int n = 0; n < 40; n++) begin
            value = 8'($urandom_range(0, 255));
            repeat ($urandom_range(1, 14)) @(negedge clk);
        end
        run_to_idle();
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/out_display.md
Name: out_display

Overview:
- Downstream consumer of the CPU's 8-bit output register.
- Converts the value to decimal with a sequential double-dabble engine and drives a 4-digit, time-multiplexed 7-segment display.
- Sits between the CPU's `out` port and the board display pins.
- Leading zeros are blanked. Conversion runs only when the input value changes.

Parameters:
- REFRESH_DIV, 16: width of the refresh counter. The scanned digit advances once every 2^REFRESH_DIV clocks.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- value  input  8  CPU output register value; may change on any clock.
- bcd  output  12  latched conversion result, {hundreds, tens, ones}, 4 bits each.
- busy  output  1  high while a conversion is in progress.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
- dig_en  output  4  digit enables, active-low one-hot, registered; bit0 = rightmost (ones) digit.

Behaviour:
- Reset (reset_n low, asynchronous, takes effect immediately):
  - state=IDLE, shadow=0, bcd=0, busy=0.
  - Refresh counter=0, digit index=0.
  - seg=7'h00, dig_en=4'b1111 (all off).
  - Any conversion in progress is abandoned; no partial result reaches bcd.
- Change detect (IDLE only):
  - On a posedge with value != shadow: shadow<=value, load shift register, iteration count<=0, state<=SHIFT.
  - Changes that occur while not IDLE are ignored; they are picked up on return to IDLE because shadow != value.
- SHIFT, 8 cycles, one iteration per clock:
  - Add 3 to each BCD nibble that is >= 5.
  - Then shift {bcd_work, bin} left by 1.
  - After the 8th iteration, state<=DONE.
- DONE, 1 cycle: bcd<=bcd_work, state<=IDLE.
- Latency and busy:
  - busy is high in SHIFT and DONE, i.e. 9 cycles.
  - The new bcd is visible after the 10th posedge counted from the sampling edge.
  - bcd changes only in DONE.
- Width rules:
  - Working nibbles are 4 bits. Max input 255 gives 2/5/5.
  - The hundreds nibble never exceeds 2 (unsigned).
- Refresh:
  - The counter increments every clock and wraps.
  - When the counter equals all-ones, digit index <= index+1 (mod 4).
  - Each clock, seg and dig_en are registered from the current index and bcd: dig_en = ~(4'b0001 << index).
- Segment codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - blank=00, minus=40.
- Blanking:
  - Digit 0 (ones) is always shown.
  - Digit 1 (tens) is blank if hundreds=0 and tens=0.
  - Digit 2 (hundreds) is blank if hundreds=0.
  - Digit 3 is blank unless the optional feature is enabled.
- Simultaneous events:
  - A refresh advance and DONE in the same cycle: the seg register captures the old bcd; the new bcd appears from the next clock.

Optional Feature:
- Macro: OUT_DISPLAY_SIGNED_EN.
- Defined:
  - value is two's complement.
  - On sample, sign<=value[7], and the converted magnitude is (value[7] ? -value : value). Range is 0..128; -128 converts to 1/2/8.
  - Digit 3 shows minus (7'h40) when sign=1, otherwise blank.
  - sign resets to 0.
- Undefined:
  - value is unsigned 0..255; no sign register; digit 3 is always blank.

Test Plan (REFRESH_DIV=2 for simulation):
- Reset with value=0, then release -> bcd=12'h000, busy=0, dig_en=1111 during reset; after release digit0 seg=3F, digits 1-3 seg=00, and no conversion starts.
- value=8'd255 -> busy high exactly 9 cycles, bcd=12'h255 after the 10th edge; scan gives digit0=6D, digit1=6D, digit2=5B, digit3=00, each held 4 clocks.
- value=8'd7 -> bcd=12'h007; digit0=07, digits 1 and 2 blank (00).
- value=100, then value=42 three cycles later -> bcd goes 12'h100 then 12'h042; busy drops for exactly 1 IDLE cycle between conversions; no intermediate bcd values.
- reset_n pulsed low during SHIFT (value=200) -> busy=0 and bcd=0 immediately; after release the converter restarts and reaches bcd=12'h200.
- With OUT_DISPLAY_SIGNED_EN, value=8'hF6 -> bcd=12'h010 and digit3=40; value=8'h80 -> bcd=12'h128. Without the macro, value=8'hF6 -> bcd=12'h246 and digit3=00.
